// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and types for the RS-232 receive engine
//
// Purpose: state encoding, oversampling constants and the frame-width helper
//          shared by uart_rs232_rx and its synchronizer.
// Ports:   none (package).
// Config:  the optional majority-vote sampler is selected with UART_RX_MAJORITY_EN
//          in uart_rs232_rx; nothing in this package depends on it.
package uart_pkg;

  // 5-bit encoding keeps the receive states the same width as the TX side.
  typedef enum logic [4:0] {
    IDLE  = 5'd0,
    START = 5'd1,
    DATA  = 5'd2,
    STOP  = 5'd3
  } rxState_t;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MID_SAMPLE = 4'd7;
  localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] NBITS_MIN  = 4'd6;
  localparam logic [3:0] NBITS_MAX  = 4'd8;

  // 6 and 7 are honoured; every other request falls back to 8 data bits.
  function automatic logic [3:0] effBits(input logic [3:0] n);
    return (n >= NBITS_MIN && n < NBITS_MAX) ? n : NBITS_MAX;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - Rx line synchronizer with falling-edge detect
//
// Purpose: brings the asynchronous Rx line into the Clk domain through
//          SYNC_STAGES flops, keeps one history flop behind them and flags a
//          falling edge (synchronized 0 with history 1). All flops reset to 1,
//          the idle level of the line, so reset release never fakes an edge.
// Ports:
//   Clk      in   system clock
//   Rst_n    in   asynchronous active-low reset
//   Rx       in   raw serial line
//   rxSync   out  synchronized line level
//   fallEdge out  high while the synchronized line has just dropped
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Rx,
  output logic rxSync,
  output logic fallEdge
);

  logic [SYNC_STAGES-1:0] syncReg;
  logic                   histReg;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      syncReg <= '1;
      histReg <= 1'b1;
    end else begin
      syncReg <= {syncReg[SYNC_STAGES-2:0], Rx};
      histReg <= syncReg[SYNC_STAGES-1];
    end
  end

  assign rxSync   = syncReg[SYNC_STAGES-1];
  assign fallEdge = ~syncReg[SYNC_STAGES-1] & histReg;

endmodule

// File: rtl/uart_rs232_rx.sv
// rtl/uart_rs232_rx.sv - RS-232 receive engine, 16x oversampled, 6/7/8 data bits
//
// Purpose: detects a start bit on the synchronized Rx line, samples each data
//          bit at mid-bit (LSB first), checks the stop bit and delivers a
//          right-justified word with a one-cycle RxDone strobe. Frame is
//          1 start, nBits data, 1 stop, no parity.
// Ports:
//   Clk      in   system clock
//   Rst_n    in   asynchronous active-low reset
//   RxEn     in   gates acceptance of new start bits only
//   Rx       in   asynchronous serial line, idle high
//   tick     in   16x baud enable, one Clk wide
//   nBits    in   data bits per frame (6, 7, else 8), captured at start bit
//   RxData   out  received word, upper unused bits zero, held until next RxDone
//   RxDone   out  one-cycle strobe, RxData updated
//   FrameErr out  one-cycle strobe with RxDone when the stop bit sampled 0
// Config:  `define UART_RX_MAJORITY_EN for a 2-of-3 vote on every bit sample.
module uart_rs232_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       RxEn,
  input  logic       Rx,
  input  logic       tick,
  input  logic [3:0] nBits,
  output logic [7:0] RxData,
  output logic       RxDone,
  output logic       FrameErr
);

  rxState_t   state;
  logic [3:0] tickCnt;
  logic [3:0] bitCnt;
  logic [3:0] nBitsReg;
  logic [7:0] shiftReg;
  logic       rxSync;
  logic       fallEdge;
  logic       lineSample;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) uSync (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Rx      (Rx),
    .rxSync  (rxSync),
    .fallEdge(fallEdge)
  );

`ifdef UART_RX_MAJORITY_EN
  // Line level captured on the two ticks before the current one; together
  // with the live level they form the vote window ending at the sample point.
  logic [1:0] sampleHist;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sampleHist <= 2'b11;
    end else if (tick) begin
      sampleHist <= {sampleHist[0], rxSync};
    end
  end

  assign lineSample = (sampleHist[1] & sampleHist[0]) |
                      (sampleHist[1] & rxSync) |
                      (sampleHist[0] & rxSync);
`else
  assign lineSample = rxSync;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      tickCnt  <= '0;
      bitCnt   <= '0;
      nBitsReg <= NBITS_MAX;
      shiftReg <= '0;
      RxData   <= '0;
      RxDone   <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      RxDone   <= 1'b0;
      FrameErr <= 1'b0;
      case (state)
        IDLE: begin
          tickCnt <= '0;
          if (fallEdge && RxEn) begin
            state <= START;
          end
        end

        START: begin
          if (tick) begin
            if (tickCnt == MID_SAMPLE) begin
              tickCnt <= '0;
              if (lineSample) begin
                // Line back high at mid start bit: treat as noise.
                state <= IDLE;
              end else begin
                state    <= DATA;
                bitCnt   <= effBits(nBits);
                nBitsReg <= effBits(nBits);
              end
            end else begin
              tickCnt <= tickCnt + 4'd1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            // 15 wraps to 0, which is also the clear on entry to STOP.
            tickCnt <= tickCnt + 4'd1;
            if (tickCnt == LAST_TICK) begin
              shiftReg <= {lineSample, shiftReg[7:1]};
              bitCnt   <= bitCnt - 4'd1;
              if (bitCnt == 4'd1) begin
                state <= STOP;
              end
            end
          end
        end

        STOP: begin
          if (tick) begin
            tickCnt <= tickCnt + 4'd1;
            if (tickCnt == LAST_TICK) begin
              state    <= IDLE;
              RxDone   <= 1'b1;
              FrameErr <= ~lineSample;
              // Bits entered at the top; short frames sit high in the register.
              RxData   <= shiftReg >> (NBITS_MAX - nBitsReg);
            end
          end
        end

        default: begin
          state   <= IDLE;
          tickCnt <= '0;
        end
      endcase
    end
  end

endmodule
